id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage feeding the execute unit. Captures decoded operands and control from decode and applies the forwarding selects from the RAW hazard unit, substituting the EX/MEM result for stale register-file values. Holds its payload under downstream backpressure and inserts one bubble on a load-use dependency. Exports the destination index and write-enable that the hazard unit compares against on the next instruction.

## Interface
- XLEN, 32, operand/data width
- REG_AW, 4, register index width
- STALL_CW, 16, width of the load-use stall counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs, in_rt, in_rd  in  REG_AW  source/destination indices
- in_rs_val, in_rt_val  in  XLEN  register-file read data
- in_alu_op  in  4  ALU opcode
- in_wb_en, in_mem_wr, in_is_load  in  1  control bits
- fwd_rs, fwd_rt  in  1  forwarding selects from hazard unit
- fwd_val  in  XLEN  EX/MEM result to forward
- flush  in  1  kill captured and incoming instruction
- out_valid  out  1  payload valid to EX
- out_ready  in  1  EX accepts
- out_a, out_b  out  XLEN  resolved operands
- out_rd  out  REG_AW  destination (to hazard unit wrt_dst)
- out_alu_op  out  4
- out_wb_en, out_mem_wr, out_is_load  out  1  (out_wb_en gated by out_valid; feeds write_to_mem)
- stall_cnt  out  STALL_CW  load-use bubbles inserted, saturating

## Operation
- Operand resolution: a = (fwd_rs && in_rs != 0) ? fwd_val : in_rs_val; b likewise with fwd_rt/in_rt. Index 0 never forwarded.
- Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
- Load-use hazard (lu): out_valid && out_is_load && out_rd != 0 && in_valid && (out_rd == in_rs || out_rd == in_rt).
- in_ready = !flush && !lu && (state == EMPTY || out_ready).
- FSM states:
  - EMPTY: out_valid=0. Capture on transfer in -> FULL.
  - FULL: out_valid=1. If out_ready: lu -> BUBBLE; capture -> FULL; else -> EMPTY. If !out_ready: hold all outputs bit-stable.
  - BUBBLE: out_valid=0, one cycle. in_ready = !flush. Capture -> FULL, else -> EMPTY. stall_cnt increments on entry, saturating at all-ones.
- flush (highest priority): next state EMPTY, out_valid=0, incoming instruction dropped, stall_cnt unchanged.
- Payload registers load only on transfer in; otherwise they hold their value.

## Timing
- Reset (async assert, sync release): state EMPTY; out_valid, out_a, out_b, out_rd, out_alu_op, all control outputs, and stall_cnt all 0. in_ready=0 while rst_n is low and 1 in the first cycle after release.
- Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- Full throughput: back-to-back transfers with no hazard.
- Load-use costs exactly one bubble cycle. The dependent instruction is accepted in the BUBBLE cycle, when the load's result is forwarded via fwd_val.
- Simultaneous transfer in and out in FULL: the new payload replaces the old one at the same edge.
- Reset asserted mid-hold: the payload is discarded immediately.

## Structure
- Package riscv_pipe_pkg: reg_idx_t (REG_AW bits), alu_op_t (4 bits), the state enum {EMPTY, FULL, BUBBLE}, and the XLEN/REG_AW defaults.
- One sub-module, operand_fwd_mux (index, forward select, forward value, register-file value -> operand), instantiated twice.

## Test plan
- Reset: hold rst_n=0 mid-stream -> all outputs 0 and state EMPTY; first cycle after release in_ready=1.
- Forwarding: in_rs=3, fwd_rs=1, fwd_val=0xDEAD, in_rs_val=0x1 -> out_a=0xDEAD next cycle. Repeat with in_rs=0 -> out_a=0x1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; on release, next instruction appears the following cycle.
- Load-use: load with rd=5 in FULL, next instruction uses rs=5 -> exactly one out_valid=0 cycle and stall_cnt=1; the dependent instruction issues one cycle later.
- Flush: flush together with in_valid in FULL -> out_valid=0 next cycle, the incoming instruction never appears, stall_cnt unchanged.
- Saturation: force 2^STALL_CW+2 load-use events -> stall_cnt stays at all-ones.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the ID/EX pipeline slice: register index, ALU opcode,
// stage FSM states and default widths.
package riscv_pipe_pkg;

    localparam int XLEN_D   = 32;
    localparam int REG_AW_D = 4;

    typedef logic [REG_AW_D-1:0] reg_idx_t;
    typedef logic [3:0]          alu_op_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        BUBBLE = 2'd2
    } state_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Operand forwarding mux: picks the EX/MEM result over the register-file
// value when the hazard unit selects it. Ports: i_idx, i_fwd, i_fwd_val, i_rf_val -> o_val.
module operand_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] i_idx,
    input  logic              i_fwd,
    input  logic [XLEN-1:0]   i_fwd_val,
    input  logic [XLEN-1:0]   i_rf_val,
    output logic [XLEN-1:0]   o_val
);

    // x0 is hardwired zero in the register file, so it is never forwarded.
    logic w_use_fwd;
    assign w_use_fwd = i_fwd && (i_idx != '0);
    assign o_val     = w_use_fwd ? i_fwd_val : i_rf_val;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: registers decoded operands/control for EX, resolves forwarding,
// holds under backpressure, inserts one bubble per load-use dependency.
// Ports: clk/rst_n; in_* decode side (valid/ready); fwd_* hazard selects;
// flush; out_* EX side (valid/ready); stall_cnt saturating bubble count.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int REG_AW   = REG_AW_D,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_AW-1:0]   in_rs,
    input  logic [REG_AW-1:0]   in_rt,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic [XLEN-1:0]     in_rs_val,
    input  logic [XLEN-1:0]     in_rt_val,
    input  alu_op_t             in_alu_op,
    input  logic                in_wb_en,
    input  logic                in_mem_wr,
    input  logic                in_is_load,
    input  logic                fwd_rs,
    input  logic                fwd_rt,
    input  logic [XLEN-1:0]     fwd_val,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_a,
    output logic [XLEN-1:0]     out_b,
    output logic [REG_AW-1:0]   out_rd,
    output alu_op_t             out_alu_op,
    output logic                out_wb_en,
    output logic                out_mem_wr,
    output logic                out_is_load,
    output logic [STALL_CW-1:0] stall_cnt
);

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [REG_AW-1:0]   r_rd;
    alu_op_t             r_alu_op;
    logic                r_wb_en;
    logic                r_mem_wr;
    logic                r_is_load;
    logic [STALL_CW-1:0] r_stall_cnt;

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_out_valid;
    logic            w_lu;
    logic            w_xfer_in;
    logic            w_enter_bubble;

    operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux_a (
        .i_idx     (in_rs),
        .i_fwd     (fwd_rs),
        .i_fwd_val (fwd_val),
        .i_rf_val  (in_rs_val),
        .o_val     (w_a)
    );

    operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_mux_b (
        .i_idx     (in_rt),
        .i_fwd     (fwd_rt),
        .i_fwd_val (fwd_val),
        .i_rf_val  (in_rt_val),
        .o_val     (w_b)
    );

    assign w_out_valid = (r_state == FULL);

    // Load result is not available until after EX, so a consumer right
    // behind a load must wait one cycle and pick it up via forwarding.
    assign w_lu = w_out_valid && r_is_load && (r_rd != '0) && in_valid &&
                  ((r_rd == in_rs) || (r_rd == in_rt));

    // rst_n gating keeps decode from seeing a ready while the stage is held.
    assign in_ready = rst_n && !flush &&
                      ((r_state != FULL) || (out_ready && !w_lu));

    assign w_xfer_in      = in_valid && in_ready;
    assign w_enter_bubble = !flush && w_out_valid && out_ready && w_lu;

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_xfer_in) w_next = FULL;
                end
                FULL: begin
                    if (out_ready) begin
                        if (w_lu)           w_next = BUBBLE;
                        else if (w_xfer_in) w_next = FULL;
                        else                w_next = EMPTY;
                    end
                end
                BUBBLE: begin
                    w_next = w_xfer_in ? FULL : EMPTY;
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rd      <= '0;
            r_alu_op  <= '0;
            r_wb_en   <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_is_load <= 1'b0;
        end else if (w_xfer_in) begin
            r_a       <= w_a;
            r_b       <= w_b;
            r_rd      <= in_rd;
            r_alu_op  <= in_alu_op;
            r_wb_en   <= in_wb_en;
            r_mem_wr  <= in_mem_wr;
            r_is_load <= in_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_enter_bubble && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid   = w_out_valid;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_rd      = r_rd;
    assign out_alu_op  = r_alu_op;
    assign out_wb_en   = r_wb_en && w_out_valid;
    assign out_mem_wr  = r_mem_wr;
    assign out_is_load = r_is_load;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, backpressure,
// load-use bubble, flush, reset mid-hold and stall counter saturation.
module tb_id_ex_stage;

    localparam int SCW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_rs, in_rt, in_rd;
    logic [31:0]    in_rs_val, in_rt_val;
    logic [3:0]     in_alu_op;
    logic           in_wb_en, in_mem_wr, in_is_load;
    logic           fwd_rs, fwd_rt;
    logic [31:0]    fwd_val;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_a, out_b;
    logic [3:0]     out_rd;
    logic [3:0]     out_alu_op;
    logic           out_wb_en, out_mem_wr, out_is_load;
    logic [SCW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(32), .REG_AW(4), .STALL_CW(SCW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .in_alu_op   (in_alu_op),
        .in_wb_en    (in_wb_en),
        .in_mem_wr   (in_mem_wr),
        .in_is_load  (in_is_load),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt),
        .fwd_val     (fwd_val),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .out_alu_op  (out_alu_op),
        .out_wb_en   (out_wb_en),
        .out_mem_wr  (out_mem_wr),
        .out_is_load (out_is_load),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic [31:0] rsv,
                         input logic [31:0] rtv, input logic [3:0] op,
                         input logic wb, input logic mw, input logic ld);
        in_valid   = v;
        in_rs      = rs;
        in_rt      = rt;
        in_rd      = rd;
        in_rs_val  = rsv;
        in_rt_val  = rtv;
        in_alu_op  = op;
        in_wb_en   = wb;
        in_mem_wr  = mw;
        in_is_load = ld;
    endtask

    initial begin
        logic [31:0] exp_cnt;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        fwd_rs    = 1'b0;
        fwd_rt    = 1'b0;
        fwd_val   = '0;
        drive(1'b1, 4'd1, 4'd2, 4'd3, 32'h11, 32'h22, 4'd1, 1'b1, 1'b1, 1'b1);
        tick; tick;

        // Reset state while an instruction is being offered
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_ctl", {25'b0, out_rd, out_wb_en, out_mem_wr, out_is_load},
            32'd0);
        chk("rst_cnt", {28'b0, stall_cnt}, 32'd0);

        drive(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", {31'b0, in_ready}, 32'd1);

        // Forwarding on rs, none on rt
        drive(1'b1, 4'd3, 4'd4, 4'd7, 32'h1, 32'h44, 4'd2, 1'b1, 1'b0, 1'b0);
        fwd_rs  = 1'b1;
        fwd_val = 32'hDEAD;
        tick;
        chk("fwd_valid", {31'b0, out_valid}, 32'd1);
        chk("fwd_a", out_a, 32'hDEAD);
        chk("fwd_b", out_b, 32'h44);
        chk("fwd_rd", {28'b0, out_rd}, 32'd7);
        chk("fwd_op", {28'b0, out_alu_op}, 32'd2);
        chk("fwd_wb", {31'b0, out_wb_en}, 32'd1);

        // rs=0 never forwarded; rt forwarded
        drive(1'b1, 4'd0, 4'd4, 4'd8, 32'h1, 32'h44, 4'd3, 1'b0, 1'b1, 1'b0);
        fwd_rt = 1'b1;
        tick;
        chk("x0_a", out_a, 32'h1);
        chk("fwdrt_b", out_b, 32'hDEAD);
        chk("bb_rd", {28'b0, out_rd}, 32'd8);
        chk("bb_mw", {31'b0, out_mem_wr}, 32'd1);
        fwd_rs = 1'b0;
        fwd_rt = 1'b0;

        // Backpressure
        drive(1'b1, 4'd1, 4'd2, 4'd9, 32'h111, 32'h222, 4'd5, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("bp_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_a", out_a, 32'h1);
            chk("bp_rd", {28'b0, out_rd}, 32'd8);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", {31'b0, in_ready}, 32'd1);
        tick;
        chk("bp_next_a", out_a, 32'h111);
        chk("bp_next_rd", {28'b0, out_rd}, 32'd9);

        // Load-use: load rd=5 then consumer of x5
        drive(1'b1, 4'd1, 4'd2, 4'd5, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b1);
        tick;
        chk("ld_isload", {31'b0, out_is_load}, 32'd1);
        drive(1'b1, 4'd5, 4'd2, 4'd6, 32'hBAD, 32'h7, 4'd4, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_ready", {31'b0, in_ready}, 32'd0);
        tick;
        chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        chk("lu_wb_gated", {31'b0, out_wb_en}, 32'd0);
        chk("lu_cnt", {28'b0, stall_cnt}, 32'd1);
        fwd_rs  = 1'b1;
        fwd_val = 32'h5555;
        #1;
        chk("bub_ready", {31'b0, in_ready}, 32'd1);
        tick;
        fwd_rs = 1'b0;
        chk("dep_valid", {31'b0, out_valid}, 32'd1);
        chk("dep_a", out_a, 32'h5555);
        chk("dep_rd", {28'b0, out_rd}, 32'd6);

        // Flush with an incoming instruction
        drive(1'b1, 4'd1, 4'd2, 4'd10, 32'hF1, 32'hF2, 4'd9, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("fl_ready", {31'b0, in_ready}, 32'd0);
        tick;
        flush = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_cnt", {28'b0, stall_cnt}, 32'd1);
        tick;
        chk("fl_gone", {31'b0, out_valid}, 32'd0);
        chk("fl_rd_kept", {28'b0, out_rd}, 32'd6);

        // Reset asserted while holding under backpressure
        drive(1'b1, 4'd1, 4'd2, 4'd11, 32'hAB, 32'hCD, 4'd6, 1'b1, 1'b1, 1'b0);
        out_ready = 1'b0;
        tick;
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_a", out_a, 32'd0);
        chk("mid_rst_cnt", {28'b0, stall_cnt}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick;
        rst_n = 1'b1;
        #1;

        // Saturation: 2^SCW + 2 load-use events
        for (int k = 0; k < (1 << SCW) + 2; k++) begin
            drive(1'b1, 4'd1, 4'd2, 4'd5, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b1);
            tick;
            drive(1'b1, 4'd5, 4'd2, 4'd6, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0);
            tick;
            exp_cnt = (k + 1 > 15) ? 32'd15 : k + 1;
            chk("sat_cnt", {28'b0, stall_cnt}, exp_cnt);
            tick;
        end
        chk("sat_final", {28'b0, stall_cnt}, 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
